vga_timing_gen: RTL and testbench

//  Raster timing source for the 640x480@60 display path. Runs from the 25 MHz pixel clock.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 94 +++++++++
 tb/tb_vga_timing_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing items for the 640x480@60 display path.
//   Default timing constants, the derived totals and sync windows, and the
//   coordinate type used for DrawX/DrawY.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL      = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL      = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  // Reset value of one {hs, vs, blank} delay stage: syncs idle high, video off.
  localparam logic [2:0] SYNC_DLY_RST = 3'b110;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: N-stage, W-bit shift register with a per-bit reset value.
//   clk   in  1  stage clock
//   rst   in  1  asynchronous, active-high; every stage loads RST_VAL
//   d     in  W  input word
//   q     out W  d delayed N cycles; N=0 makes q combinationally equal to d
module vga_delay_line #(
  parameter int               N       = 1,
  parameter int               W       = 1,
  parameter logic [W-1:0]     RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // At least one stage is always built so N=0 stays legal; it is then unused
  // on the output and trimmed by synthesis.
  localparam int NS   = (N < 1) ? 1 : N;
  localparam int LAST = NS - 1;

  logic [W-1:0] stages [NS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) stages[i] <= RST_VAL;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < NS; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = (N == 0) ? d : stages[LAST];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source running on the pixel clock.
//   vga_clk      in   1       pixel clock
//   reset        in   1       asynchronous, active-high
//   DrawX        out  10      pixel column, 0..H_TOTAL-1
//   DrawY        out  10      line, 0..V_TOTAL-1
//   blank        out  1       1 = active video
//   hs, vs       out  1       active-low syncs aligned with DrawX/DrawY
//   hs_d, vs_d   out  1       syncs delayed PIPE_DELAY cycles
//   blank_d      out  1       blank delayed PIPE_DELAY cycles
//   frame_start  out  1       one-cycle pulse when the raster wraps to (0,0)
//   frame_count  out  FCNT_W  frames completed since reset, wrapping
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int PIPE_DELAY = 1,
  parameter int FCNT_W     = 8
) (
  input  logic              vga_clk,
  input  logic              reset,
  output coord_t            DrawX,
  output coord_t            DrawY,
  output logic              blank,
  output logic              hs,
  output logic              vs,
  output logic              hs_d,
  output logic              vs_d,
  output logic              blank_d,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_count
);

  localparam coord_t H_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS_LT = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_LT = coord_t'(V_VISIBLE);
  localparam coord_t H_SS     = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t H_SE     = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t V_SS     = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t V_SE     = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  coord_t next_x, next_y;
  logic   line_end, frame_wrap;

  always_comb begin
    line_end   = (DrawX == H_LAST);
    frame_wrap = line_end && (DrawY == V_LAST);
    next_x     = line_end ? '0 : DrawX + coord_t'(1);
    next_y     = DrawY;
    if (line_end) next_y = (DrawY == V_LAST) ? '0 : DrawY + coord_t'(1);
  end

  // Decode from the next counter values so the registered flags line up
  // with the registered coordinates.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= next_x;
      DrawY       <= next_y;
      hs          <= !((next_x >= H_SS) && (next_x <= H_SE));
      vs          <= !((next_y >= V_SS) && (next_y <= V_SE));
      blank       <= (next_x < H_VIS_LT) && (next_y < V_VIS_LT);
      frame_start <= frame_wrap;
      if (frame_wrap) frame_count <= frame_count + FCNT_W'(1);
    end
  end

  // Matches the renderers' one-register colour latency (or more).
  vga_delay_line #(
    .N       (PIPE_DELAY),
    .W       (3),
    .RST_VAL (SYNC_DLY_RST)
  ) u_sync_dly (
    .clk (vga_clk),
    .rst (reset),
    .d   ({hs, vs, blank}),
    .q   ({hs_d, vs_d, blank_d})
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  typedef struct packed {
    int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp;
  } geom_t;

  localparam geom_t G_DEF   = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam geom_t G_SMALL = '{8, 2, 3, 2, 6, 1, 2, 1};   // 15 x 10 = 150 cycles/frame

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Cycles since reset release: the whole model is a function of this.
  longint k;
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  // Default geometry, PIPE_DELAY=1
  logic [9:0] d1_x, d1_y;
  logic d1_hs, d1_vs, d1_blank, d1_hsd, d1_vsd, d1_blankd, d1_fs;
  logic [7:0] d1_fc;
  // Small geometry, PIPE_DELAY=0
  logic [9:0] s0_x, s0_y;
  logic s0_hs, s0_vs, s0_blank, s0_hsd, s0_vsd, s0_blankd, s0_fs;
  logic [7:0] s0_fc;
  // Small geometry, PIPE_DELAY=3
  logic [9:0] s3_x, s3_y;
  logic s3_hs, s3_vs, s3_blank, s3_hsd, s3_vsd, s3_blankd, s3_fs;
  logic [7:0] s3_fc;

  vga_timing_gen #(.PIPE_DELAY(1)) dut_p1 (
    .vga_clk(clk), .reset(rst), .DrawX(d1_x), .DrawY(d1_y), .blank(d1_blank),
    .hs(d1_hs), .vs(d1_vs), .hs_d(d1_hsd), .vs_d(d1_vsd), .blank_d(d1_blankd),
    .frame_start(d1_fs), .frame_count(d1_fc));

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .PIPE_DELAY(0)) dut_s0 (
    .vga_clk(clk), .reset(rst), .DrawX(s0_x), .DrawY(s0_y), .blank(s0_blank),
    .hs(s0_hs), .vs(s0_vs), .hs_d(s0_hsd), .vs_d(s0_vsd), .blank_d(s0_blankd),
    .frame_start(s0_fs), .frame_count(s0_fc));

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .PIPE_DELAY(3)) dut_s3 (
    .vga_clk(clk), .reset(rst), .DrawX(s3_x), .DrawY(s3_y), .blank(s3_blank),
    .hs(s3_hs), .vs(s3_vs), .hs_d(s3_hsd), .vs_d(s3_vsd), .blank_d(s3_blankd),
    .frame_start(s3_fs), .frame_count(s3_fc));

  // {hs, vs, blank} at raster step k, straight from the decode rules.
  function automatic logic [2:0] sync_at(geom_t g, longint kk);
    longint ht, fl, pos, x, y;
    logic h, v, b;
    ht  = g.hv + g.hfp + g.hsw + g.hbp;
    fl  = ht * (g.vv + g.vfp + g.vsw + g.vbp);
    pos = kk % fl;
    x   = pos % ht;
    y   = pos / ht;
    h   = !(x >= g.hv + g.hfp && x < g.hv + g.hfp + g.hsw);
    v   = !(y >= g.vv + g.vfp && y < g.vv + g.vfp + g.vsw);
    b   = (x < g.hv) && (y < g.vv);
    return {h, v, b};
  endfunction

  // {x, y, hs, vs, blank, hs_d, vs_d, blank_d, frame_start, frame_count}
  function automatic logic [34:0] expect_vec(geom_t g, longint kk, int d);
    longint ht, fl, pos, x, y, fc;
    logic [2:0] s, sd;
    logic fs;
    logic [9:0] xv, yv;
    logic [7:0] fcv;
    ht  = g.hv + g.hfp + g.hsw + g.hbp;
    fl  = ht * (g.vv + g.vfp + g.vsw + g.vbp);
    pos = kk % fl;
    x   = pos % ht;
    y   = pos / ht;
    fc  = (kk / fl) % 256;
    s   = sync_at(g, kk);
    sd  = (kk - d < 0) ? 3'b110 : sync_at(g, kk - d);
    fs  = (kk > 0) && (pos == 0);
    xv  = x[9:0];
    yv  = y[9:0];
    fcv = fc[7:0];
    return {xv, yv, s, sd, fs, fcv};
  endfunction

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t k=%0d)", name, act, exp, $time, k);
  endtask

  task automatic chk_vec(string name, logic [34:0] act, logic [34:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s {x,y,hs,vs,blk,hs_d,vs_d,blk_d,fs,fc}: got %h expected %h (k=%0d)",
                  name, act, exp, k);
  endtask

  int hs_low_cnt = 0;
  int vs_low_cnt = 0;
  int fs_cnt     = 0;

  always @(negedge clk) begin
    chk_vec("dut_p1", {d1_x, d1_y, d1_hs, d1_vs, d1_blank, d1_hsd, d1_vsd, d1_blankd, d1_fs, d1_fc},
            expect_vec(G_DEF, k, 1));
    chk_vec("dut_s0", {s0_x, s0_y, s0_hs, s0_vs, s0_blank, s0_hsd, s0_vsd, s0_blankd, s0_fs, s0_fc},
            expect_vec(G_SMALL, k, 0));
    chk_vec("dut_s3", {s3_x, s3_y, s3_hs, s3_vs, s3_blank, s3_hsd, s3_vsd, s3_blankd, s3_fs, s3_fc},
            expect_vec(G_SMALL, k, 3));

    if (k >= 1 && k <= 800 && !d1_hs) hs_low_cnt++;
    if (k >= 1 && k <= 150 && !s0_vs) vs_low_cnt++;
    if (k >= 1 && k <= 300 && s0_fs)  fs_cnt++;

    // Hand-computed pins on the model's key instants.
    if (k == 1)   chk("first_x", d1_x, 1);
    if (k == 639) chk("blank_last_visible", d1_blank, 1);
    if (k == 640) chk("blank_first_blank", d1_blank, 0);
    if (k == 655) chk("hs_before_sync", d1_hs, 1);
    if (k == 656) chk("hs_sync_start", d1_hs, 0);
    if (k == 656) chk("hs_d_lag1_high", d1_hsd, 1);
    if (k == 657) chk("hs_d_lag1_low", d1_hsd, 0);
    if (k == 800) chk("hs_low_cycles_line", hs_low_cnt, 96);
    if (k == 800) chk("line_wrap_y", d1_y, 1);
    if (k == 10)  chk("p0_hs_d_same", s0_hsd, 0);
    if (k == 150) chk("vs_low_cycles_frame", vs_low_cnt, 30);
    if (k == 150) chk("frame_start_first", s0_fs, 1);
    if (k == 150) chk("frame_count_1", s0_fc, 1);
    if (k == 151) chk("frame_start_single", s0_fs, 0);
    if (k == 152) chk("p3_blank_d_still_low", s3_blankd, 0);
    if (k == 153) chk("p3_blank_d_rise", s3_blankd, 1);
    if (k == 300) chk("frame_start_count_2", fs_cnt, 2);
    if (k == 300) chk("frame_count_2", s3_fc, 2);
    if (k == 255 * 150) chk("frame_count_255", s3_fc, 255);
    if (k == 256 * 150) chk("frame_count_wrap0", s3_fc, 0);
    if (k == 256 * 150) chk("frame_start_at_wrap", s3_fs, 1);
  end

  initial begin
    int guard;
    bit found;
    #22 rst = 1'b0;

    repeat (258 * 150) @(posedge clk);

    // Land the small raster in the horizontal sync of a visible line.
    found = 0;
    guard = 0;
    while (!found && guard < 400) begin
      @(negedge clk);
      if (s0_x == 10 && s0_y == 5) found = 1;
      guard++;
    end
    chk("mid_reset_point_reached", found, 1);
    chk("pre_reset_hs_low", s0_hs, 0);
    chk("pre_reset_fc_nonzero", s0_fc, 2);

    #2 rst = 1'b1;
    #1;
    chk("async_rst_x", s0_x, 0);
    chk("async_rst_y", s0_y, 0);
    chk("async_rst_hs", s0_hs, 1);
    chk("async_rst_blank", s0_blank, 1);
    chk("async_rst_fc", s0_fc, 0);
    chk("async_rst_fs", s0_fs, 0);
    chk("async_rst_p1_x", d1_x, 0);
    chk("async_rst_p1_blank_d", d1_blankd, 0);
    chk("async_rst_p3_hs_d", s3_hsd, 1);

    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_x", s0_x, 1);
    chk("post_rst_y", s0_y, 0);
    chk("post_rst_fc", s0_fc, 0);
    chk("post_rst_fs", s0_fs, 0);
    chk("post_rst_p1_x", d1_x, 1);

    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
